// File: rtl/fwd_pkg.sv
// Shared types and helpers for the ID-stage operand forwarding unit.
package fwd_pkg;

    localparam int REG_ADDR_W = 5;

    // One in-flight writer as seen from the ID stage
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  we;
        logic                  is_load;
    } fwd_entry_t;

    function automatic int fwd_sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_port_sel.sv
// Per-port priority match over the tracked stages: picks the youngest
// producer of rs_addr, flags a load that is not ready yet, and muxes the data.
module fwd_port_sel
    import fwd_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int SEL_W    = 2
) (
    input  logic [REG_ADDR_W-1:0]  rs_addr,
    input  logic [XLEN-1:0]        rs_data,
    input  fwd_entry_t [DEPTH-1:0] entries,
    input  logic [DEPTH*XLEN-1:0]  stage_data,
    output logic [XLEN-1:0]        op_data,
    output logic [SEL_W-1:0]       sel,
    output logic                   hazard
);

    // Scan oldest to youngest so the lowest matching stage wins.
    always_comb begin
        op_data = rs_data;
        sel     = '0;
        hazard  = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (entries[k].valid && entries[k].we &&
                entries[k].rd == rs_addr && rs_addr != '0) begin
                op_data = stage_data[k*XLEN +: XLEN];
                sel     = SEL_W'(k + 1);
                hazard  = entries[k].is_load && (k < LOAD_LAT);
            end
        end
    end

endmodule

// File: rtl/id_operand_forward_unit.sv
// ID-stage operand forwarding and load-use hazard unit.
// Optional performance counters are enabled with `define FWD_PERF_CNT_EN.
module id_operand_forward_unit
    import fwd_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NUM_RS   = 2,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              id_valid,
    input  logic [NUM_RS*REG_ADDR_W-1:0]      id_rs_addr,
    input  logic [NUM_RS*XLEN-1:0]            id_rs_data,
    input  logic [REG_ADDR_W-1:0]             id_rd,
    input  logic                              id_we,
    input  logic                              id_is_load,
    input  logic [DEPTH*XLEN-1:0]             stage_data,
    input  logic                              pipe_hold,
    input  logic                              flush,
    output logic [NUM_RS*XLEN-1:0]            op_data,
    output logic [NUM_RS*fwd_sel_w(DEPTH)-1:0] op_fwd_sel,
    output logic                              stall,
    output logic [31:0]                       perf_stall_cnt,
    output logic [31:0]                       perf_fwd_cnt
);

    localparam int SEL_W = fwd_sel_w(DEPTH);

    fwd_entry_t [DEPTH-1:0] entries;
    logic       [NUM_RS-1:0] hazard;
    logic                    issue;

    for (genvar p = 0; p < NUM_RS; p++) begin : g_port
        fwd_port_sel #(
            .XLEN     (XLEN),
            .DEPTH    (DEPTH),
            .LOAD_LAT (LOAD_LAT),
            .SEL_W    (SEL_W)
        ) u_sel (
            .rs_addr    (id_rs_addr[p*REG_ADDR_W +: REG_ADDR_W]),
            .rs_data    (id_rs_data[p*XLEN +: XLEN]),
            .entries    (entries),
            .stage_data (stage_data),
            .op_data    (op_data[p*XLEN +: XLEN]),
            .sel        (op_fwd_sel[p*SEL_W +: SEL_W]),
            .hazard     (hazard[p])
        );
    end

    assign stall = id_valid && !flush && (|hazard);
    assign issue = id_valid && !stall && !flush && !pipe_hold;

    // Writes to x0 are recorded as non-writing so they never forward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entries <= '0;
        end else if (!pipe_hold) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                entries[k] <= entries[k-1];
            end
            if (issue) begin
                entries[0].valid   <= 1'b1;
                entries[0].rd      <= id_rd;
                entries[0].we      <= id_we && (id_rd != '0);
                entries[0].is_load <= id_is_load;
            end else begin
                entries[0] <= '0;
            end
        end
    end

`ifdef FWD_PERF_CNT_EN
    // Saturating counters, frozen along with the pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
            perf_fwd_cnt   <= '0;
        end else begin
            if (stall && !pipe_hold && perf_stall_cnt != 32'hFFFF_FFFF) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (issue && (|op_fwd_sel) && perf_fwd_cnt != 32'hFFFF_FFFF) begin
                perf_fwd_cnt <= perf_fwd_cnt + 32'd1;
            end
        end
    end
`else
    assign perf_stall_cnt = 32'd0;
    assign perf_fwd_cnt   = 32'd0;
`endif

endmodule
